inorder_issue_stage: RTL and testbench
======================================

// Module: inorder_issue_stage
// PURPOSE
//  Consumer side of the decode control word. Buffers decoded uops in an in-order FIFO and checks
//  the head entry against a 32-entry register scoreboard and per-unit busy flags. Emits one
//  registered issue packet per cycle to the RRD/execute stage. Sits between DEC and RRD.
// PARAMETERS
//  DEPTH      4   FIFO entries; power of two, >=2
//  PTR_W      $clog2(DEPTH)   derived; do not override
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   reset; asynchronous, active-high
//  flush        in   1   drop all queued uops and the issue register (sync)
//  enq_valid    in   1   DEC presents a uop
//  enq_ready    out  1   queue can accept (== !full)
//  enq_uop      in   ctrl_sigs packet   uopcode(6) exu_type(2) has_rd/rs1/rs2 rd/rs1/rs2(5 each) imm_type(3) is_br packed_imm(20)
//  exu_busy     in   4   per exe_unit_type busy (alu,mul,div,mem); 1 = cannot accept this cycle
//  wb_valid     in   1   writeback completes
//  wb_rd        in   5   writeback destination; clears its scoreboard bit
//  iss_valid    out  1   registered: iss_uop valid this cycle (single-cycle pulse per uop)
//  iss_uop      out  ctrl_sigs packet   registered copy of the issued entry
//  sb_busy      out  32  scoreboard state, for debug/assertions
// BEHAVIOUR
//  - Reset: FIFO empty (head=tail=0, count=0), iss_valid=0, iss_uop=0, sb_busy=0, enq_ready=1.
//  - Enqueue: enq_valid & enq_ready -> write at tail, tail+1 mod DEPTH. No enqueue when full, even
//    if the head issues in the same cycle.
//  - Effective busy is eff = sb_busy & ~(wb_valid ? onehot(wb_rd) : 0). Writeback bypasses the
//    scoreboard in the same cycle.
//  - The head can issue (go) when all of these hold:
//    - count != 0;
//    - !(has_rs1 & rs1!=0 & eff[rs1]);
//    - !(has_rs2 & rs2!=0 & eff[rs2]);
//    - !(has_rd & rd!=0 & eff[rd])  (WAW);
//    - !exu_busy[exu_type].
//  - On go: head+1, iss_valid<=1, iss_uop<=head entry. If has_rd & rd!=0, sb_busy[rd]<=1.
//    Otherwise iss_valid<=0 and iss_uop holds.
//  - Scoreboard update per bit: set on go, cleared by wb, set wins if same rd. x0 is never set.
//    wb to an idle reg is harmless.
//  - Latency: uop enqueued at edge N -> earliest iss_valid high after edge N+1 (2-cycle min).
//    Throughput is 1 uop/cycle when there are no hazards.
//  - Simultaneous enq and go: count unchanged, both pointers advance.
//  - Pointers wrap at DEPTH. count is PTR_W+1 bits.
//  - flush: head=tail=count=0, iss_valid<=0. sb_busy is NOT cleared (in-flight ops still write
//    back), but a wb in the flush cycle still clears. Flush beats enq and go in the same cycle.
//  - rst asserted mid-operation: all state returns to reset values immediately; pending wb is lost.
// STRUCTURE
//  - Shared package (issue_pkg):
//    - issue_uop_t packed struct, reusing uopc/exut/immt enum types;
//    - EXU_COUNT=4.
//  - Sub-module issue_scoreboard:
//    - 32 busy flops;
//    - set port (en,rd) and clear port (en,rd);
//    - eff_busy output and rs1/rs2/rd hazard lookup.
//  - FIFO storage is an unpacked array of issue_uop_t in this module.
// TESTING
//  1 Reset, enq ADDI rd=5 rs1=1 at cycle 0 -> iss_valid=1 at cycle 2, iss_uop.rd=5, sb_busy[5]=1.
//  2 ADD rd=6 rs1=5 after #1, no wb -> stalls, iss_valid=0; wb_valid=1 wb_rd=5 -> issues same
//    cycle, iss_valid next cycle, sb_busy[5]=0 sb_busy[6]=1.
//  3 Fill 4 entries with exu_busy=4'b1111 -> enq_ready=0 on 4th. 5th enq_valid is ignored.
//    Release busy -> 4 back-to-back iss_valid pulses in order, pointers wrap correctly.
//  4 MUL with exu_busy[1]=1 for 3 cycles -> issues on the first cycle busy=0.
//    ADD behind it does not overtake.
//  5 rd=0 uop (has_rd=1) -> issues, sb_busy stays 0. A second rd=0 uop also issues without a
//    WAW stall.
//  6 flush with 3 queued and sb_busy[7]=1 -> count=0, iss_valid=0 next cycle, sb_busy[7] still 1.
//    Async rst mid-stall clears all.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types for the in-order issue stage: decoded uop packet, unit types and helpers.
package issue_pkg;

    localparam int EXU_COUNT = 4;

    typedef enum logic [5:0] {
        UOPC_NOP  = 6'd0,
        UOPC_ADD  = 6'd1,
        UOPC_ADDI = 6'd2,
        UOPC_MUL  = 6'd3,
        UOPC_DIV  = 6'd4,
        UOPC_LD   = 6'd5,
        UOPC_ST   = 6'd6,
        UOPC_BEQ  = 6'd7
    } uopc_t;

    typedef enum logic [1:0] {
        EXUT_ALU = 2'd0,
        EXUT_MUL = 2'd1,
        EXUT_DIV = 2'd2,
        EXUT_MEM = 2'd3
    } exut_t;

    typedef enum logic [2:0] {
        IMMT_NONE = 3'd0,
        IMMT_I    = 3'd1,
        IMMT_S    = 3'd2,
        IMMT_B    = 3'd3,
        IMMT_U    = 3'd4,
        IMMT_J    = 3'd5
    } immt_t;

    typedef struct packed {
        uopc_t       uopc;
        exut_t       exut;
        logic        has_rd;
        logic        has_rs1;
        logic        has_rs2;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        immt_t       immt;
        logic        is_br;
        logic [19:0] imm;
    } issue_uop_t;

    function automatic logic [31:0] reg_onehot(input logic [4:0] idx);
        reg_onehot = 32'd1 << idx;
    endfunction

    // A named register operand is only a hazard when it is real (not x0) and still pending.
    function automatic logic reg_hazard(input logic [31:0] eff, input logic en, input logic [4:0] idx);
        reg_hazard = en && (idx != 5'd0) && eff[idx];
    endfunction

endpackage

// File: rtl/inorder_issue_stage_scoreboard.sv
// 32-entry register scoreboard with set/clear ports and same-cycle writeback bypass on lookups.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [4:0]  set_rd,
    input  logic        clr_en,
    input  logic [4:0]  clr_rd,
    input  logic        chk_rs1_en,
    input  logic [4:0]  chk_rs1,
    input  logic        chk_rs2_en,
    input  logic [4:0]  chk_rs2,
    input  logic        chk_rd_en,
    input  logic [4:0]  chk_rd,
    output logic [31:0] busy,
    output logic        hazard
);

    logic [31:0] busy_r;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic [31:0] eff_busy_s;

    // Decode set/clear requests into masks; x0 is never marked busy.
    always_comb begin
        set_mask_s = 32'd0;
        clr_mask_s = 32'd0;
        if (set_en && (set_rd != 5'd0)) begin
            set_mask_s = reg_onehot(set_rd);
        end else begin
            set_mask_s = 32'd0;
        end
        if (clr_en) begin
            clr_mask_s = reg_onehot(clr_rd);
        end else begin
            clr_mask_s = 32'd0;
        end
    end

    assign eff_busy_s = busy_r & ~clr_mask_s;

    // Hazard lookup sees the writeback of this cycle already applied.
    always_comb begin
        hazard = reg_hazard(eff_busy_s, chk_rs1_en, chk_rs1)
               | reg_hazard(eff_busy_s, chk_rs2_en, chk_rs2)
               | reg_hazard(eff_busy_s, chk_rd_en,  chk_rd);
    end

    // Busy flops: a set for the same register wins over its clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= eff_busy_s | set_mask_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/inorder_issue_stage.sv
// In-order issue stage: uop FIFO, head hazard check against scoreboard and unit busy, registered issue.
module inorder_issue_stage
    import issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        enq_valid,
    output logic        enq_ready,
    input  issue_uop_t  enq_uop,
    input  logic [3:0]  exu_busy,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        iss_valid,
    output issue_uop_t  iss_uop,
    output logic [31:0] sb_busy
);

    localparam int PTR_W = $clog2(DEPTH);

    issue_uop_t       mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             iss_valid_r;
    issue_uop_t       iss_uop_r;

    issue_uop_t       head_uop_s;
    logic             full_s;
    logic             enq_fire_s;
    logic             hazard_s;
    logic             go_s;
    logic             sb_set_s;

    assign head_uop_s = mem_r[head_r];
    assign full_s     = (count_r == (PTR_W+1)'(DEPTH));
    assign enq_ready  = ~full_s;
    // Full blocks enqueue even if the head leaves this cycle, keeping ready independent of hazards.
    assign enq_fire_s = enq_valid & ~full_s & ~flush;

    issue_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en     (sb_set_s),
        .set_rd     (head_uop_s.rd),
        .clr_en     (wb_valid),
        .clr_rd     (wb_rd),
        .chk_rs1_en (head_uop_s.has_rs1),
        .chk_rs1    (head_uop_s.rs1),
        .chk_rs2_en (head_uop_s.has_rs2),
        .chk_rs2    (head_uop_s.rs2),
        .chk_rd_en  (head_uop_s.has_rd),
        .chk_rd     (head_uop_s.rd),
        .busy       (sb_busy),
        .hazard     (hazard_s)
    );

    // Issue decision for the head entry; flush suppresses it.
    always_comb begin
        go_s     = 1'b0;
        sb_set_s = 1'b0;
        if ((count_r != (PTR_W+1)'(0)) && !hazard_s && !exu_busy[head_uop_s.exut] && !flush) begin
            go_s     = 1'b1;
            sb_set_s = head_uop_s.has_rd;
        end else begin
            go_s     = 1'b0;
            sb_set_s = 1'b0;
        end
    end

    // FIFO storage write at tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (enq_fire_s) begin
            mem_r[tail_r] <= enq_uop;
        end
    end

    // Pointers and occupancy; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= PTR_W'(0);
            tail_r  <= PTR_W'(0);
            count_r <= (PTR_W+1)'(0);
        end else if (flush) begin
            head_r  <= PTR_W'(0);
            tail_r  <= PTR_W'(0);
            count_r <= (PTR_W+1)'(0);
        end else begin
            if (go_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            if (enq_fire_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            case ({enq_fire_s, go_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue register: one-cycle valid pulse, packet holds between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_r <= 1'b0;
            iss_uop_r   <= '0;
        end else if (go_s) begin
            iss_valid_r <= 1'b1;
            iss_uop_r   <= head_uop_s;
        end else begin
            iss_valid_r <= 1'b0;
        end
    end

    assign iss_valid = iss_valid_r;
    assign iss_uop   = iss_uop_r;

endmodule

// File: tb/tb_inorder_issue_stage.sv
// Directed bench for inorder_issue_stage with a queue-based reference model and literal spot checks.
module tb_inorder_issue_stage;
    import issue_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    issue_uop_t  enq_uop;
    logic [3:0]  exu_busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        iss_valid;
    issue_uop_t  iss_uop;
    logic [31:0] sb_busy;

    int checks = 0;
    int errors = 0;

    inorder_issue_stage #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_uop   (enq_uop),
        .exu_busy  (exu_busy),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .iss_valid (iss_valid),
        .iss_uop   (iss_uop),
        .sb_busy   (sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic issue_uop_t mk(input uopc_t op, input exut_t ex,
                                      input logic hrd, input logic [4:0] rd,
                                      input logic hr1, input logic [4:0] r1,
                                      input logic hr2, input logic [4:0] r2);
        issue_uop_t u;
        u = '0;
        u.uopc = op; u.exut = ex;
        u.has_rd = hrd; u.rd = rd;
        u.has_rs1 = hr1; u.rs1 = r1;
        u.has_rs2 = hr2; u.rs2 = r2;
        u.immt = IMMT_I; u.is_br = 1'b0;
        u.imm = {15'd0, rd} ^ 20'hA5A5A;
        return u;
    endfunction

    // Reference model: a queue of pending uops and a boolean per register.
    issue_uop_t  mq[$];
    logic [31:0] m_sb;
    logic        m_iv;
    issue_uop_t  m_iu;

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] eff;
        issue_uop_t  h;
        bit          go;
        bit          room;
        if (rst) begin
            mq.delete();
            m_sb = 32'd0;
            m_iv = 1'b0;
            m_iu = '0;
        end else begin
            eff = m_sb;
            if (wb_valid) eff[wb_rd] = 1'b0;
            room = (mq.size() < 4);
            go = 1'b0;
            if (mq.size() > 0) begin
                h = mq[0];
                go = !(h.has_rs1 && h.rs1 != 5'd0 && eff[h.rs1])
                  && !(h.has_rs2 && h.rs2 != 5'd0 && eff[h.rs2])
                  && !(h.has_rd  && h.rd  != 5'd0 && eff[h.rd])
                  && !exu_busy[h.exut];
            end
            m_sb = eff;
            if (flush) begin
                mq.delete();
                m_iv = 1'b0;
            end else begin
                if (go) begin
                    m_iv = 1'b1;
                    m_iu = mq.pop_front();
                    if (m_iu.has_rd && m_iu.rd != 5'd0) m_sb[m_iu.rd] = 1'b1;
                end else begin
                    m_iv = 1'b0;
                end
                if (enq_valid && room) mq.push_back(enq_uop);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("iss_valid", 64'(iss_valid), 64'(m_iv));
            chk("iss_uop",   64'(iss_uop),   64'(m_iu));
            chk("sb_busy",   64'(sb_busy),   64'(m_sb));
            chk("enq_ready", 64'(enq_ready), 64'(mq.size() < 4));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_uop = '0;
        exu_busy = 4'd0; wb_valid = 1'b0; wb_rd = 5'd0;
        #1 rst = 1'b1;
        cyc(); cyc();
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_sb_busy",   64'(sb_busy),   64'd0);
        chk("rst_iss_uop",   64'(iss_uop),   64'd0);
        rst = 1'b0;
        cyc();

        // 1: ADDI rd=5 rs1=1, two-cycle latency
        enq_valid = 1'b1; enq_uop = mk(UOPC_ADDI, EXUT_ALU, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0, 5'd0);
        cyc();
        enq_valid = 1'b0;
        chk("t1_not_yet", 64'(iss_valid), 64'd0);
        cyc();
        chk("t1_valid", 64'(iss_valid), 64'd1);
        chk("t1_rd",    64'(iss_uop.rd), 64'd5);
        chk("t1_sb5",   64'(sb_busy[5]), 64'd1);

        // 2: RAW stall on x5 until writeback bypasses it
        enq_valid = 1'b1; enq_uop = mk(UOPC_ADD, EXUT_ALU, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd2);
        cyc();
        enq_valid = 1'b0;
        cyc();
        chk("t2_stall_a", 64'(iss_valid), 64'd0);
        cyc();
        chk("t2_stall_b", 64'(iss_valid), 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        cyc();
        wb_valid = 1'b0;
        chk("t2_valid", 64'(iss_valid), 64'd1);
        chk("t2_rd",    64'(iss_uop.rd), 64'd6);
        chk("t2_sb5",   64'(sb_busy[5]), 64'd0);
        chk("t2_sb6",   64'(sb_busy[6]), 64'd1);

        // 3: fill while all units busy, overflow attempt, then drain in order with pointer wrap
        exu_busy = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1;
            enq_uop = mk(UOPC_ADDI, EXUT_ALU, 1'b1, 5'(10 + i), 1'b0, 5'd0, 1'b0, 5'd0);
            cyc();
        end
        chk("t3_full", 64'(enq_ready), 64'd0);
        enq_uop = mk(UOPC_ADDI, EXUT_ALU, 1'b1, 5'd14, 1'b0, 5'd0, 1'b0, 5'd0);
        cyc();
        enq_valid = 1'b0;
        chk("t3_still_full", 64'(enq_ready), 64'd0);
        exu_busy = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t3_drain_valid", 64'(iss_valid), 64'd1);
            chk("t3_drain_rd",    64'(iss_uop.rd), 64'(10 + i));
        end
        cyc();
        chk("t3_fifth_dropped", 64'(iss_valid), 64'd0);

        // 4: MUL blocked by its unit; younger ADD must wait behind it
        exu_busy = 4'b0010;
        enq_valid = 1'b1; enq_uop = mk(UOPC_MUL, EXUT_MUL, 1'b1, 5'd20, 1'b1, 5'd1, 1'b1, 5'd2);
        cyc();
        enq_uop = mk(UOPC_ADD, EXUT_ALU, 1'b1, 5'd21, 1'b1, 5'd3, 1'b0, 5'd0);
        cyc();
        enq_valid = 1'b0;
        cyc(); cyc();
        chk("t4_blocked", 64'(iss_valid), 64'd0);
        exu_busy = 4'b0000;
        cyc();
        chk("t4_mul_rd", 64'(iss_uop.rd), 64'd20);
        chk("t4_mul_valid", 64'(iss_valid), 64'd1);
        cyc();
        chk("t4_add_rd", 64'(iss_uop.rd), 64'd21);

        // 5: rd=0 uops never mark the scoreboard and never WAW-stall
        enq_valid = 1'b1; enq_uop = mk(UOPC_ADDI, EXUT_ALU, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0);
        cyc();
        enq_uop = mk(UOPC_ADD, EXUT_ALU, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
        cyc();
        enq_valid = 1'b0;
        chk("t5_first", 64'(iss_valid), 64'd1);
        cyc();
        chk("t5_second", 64'(iss_valid), 64'd1);
        chk("t5_sb0",    64'(sb_busy[0]), 64'd0);

        // 6: flush keeps the scoreboard, wb in flush cycle still clears, async reset clears all
        enq_valid = 1'b1; enq_uop = mk(UOPC_LD, EXUT_MEM, 1'b1, 5'd7, 1'b1, 5'd2, 1'b0, 5'd0);
        cyc();
        enq_valid = 1'b0;
        cyc();
        chk("t6_sb7_set", 64'(sb_busy[7]), 64'd1);
        exu_busy = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_uop = mk(UOPC_ADDI, EXUT_ALU, 1'b1, 5'(24 + i), 1'b0, 5'd0, 1'b0, 5'd0);
            cyc();
        end
        enq_valid = 1'b0;
        flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd6;
        cyc();
        flush = 1'b0; wb_valid = 1'b0;
        chk("t6_flush_iv",  64'(iss_valid), 64'd0);
        chk("t6_flush_rdy", 64'(enq_ready), 64'd1);
        chk("t6_sb7_kept",  64'(sb_busy[7]), 64'd1);
        chk("t6_sb6_wb",    64'(sb_busy[6]), 64'd0);
        exu_busy = 4'b0000;
        cyc(); cyc();
        chk("t6_empty", 64'(iss_valid), 64'd0);
        enq_valid = 1'b1; enq_uop = mk(UOPC_ADD, EXUT_ALU, 1'b1, 5'd8, 1'b1, 5'd7, 1'b0, 5'd0);
        cyc();
        enq_valid = 1'b0;
        cyc();
        chk("t6_stall", 64'(iss_valid), 64'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_sb",  64'(sb_busy),   64'd0);
        chk("t6_rst_iv",  64'(iss_valid), 64'd0);
        chk("t6_rst_rdy", 64'(enq_ready), 64'd1);
        chk("t6_rst_uop", 64'(iss_uop),   64'd0);
        cyc();
        rst = 1'b0;
        cyc(); cyc();
        chk("t6_after_rst", 64'(iss_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
